// File: rtl/fetch_unit.sv
// -----------------------------------------------------------------------------
// fetch_unit
//
// Instruction fetch front end. Walks a fetch PC (fpc), issues word requests to
// the icache, tags each accepted request with its PC, and pairs the in-order
// icache responses with those tags into a small fetch queue. The head of the
// queue is presented to the next stage.
//
// A misaligned fetch PC turns into an address-error entry once every useful
// response ahead of it is in the queue. After that the unit parks in HALT
// until a flush redirects it.
//
// Ports
//   clk, rst              clock, synchronous active-high reset
//   flush, flush_pc       redirect: drop all queued/in-flight work, restart
//   branch, predict_pc    predictor taken/target for the current fpc
//   stall, ns_ready       downstream hold / next stage can accept
//   req_valid, req_addr   icache request (req_addr is always fpc)
//   req_addr_ok           icache accepted the request
//   resp_data_ok          icache returns one instruction, in request order
//   resp_rdata            returned instruction
//   out_valid             head of the fetch queue is presented
//   out_pc, out_inst      head entry PC / instruction (0 on address error)
//   out_adef              head entry carries an address-error exception
// -----------------------------------------------------------------------------
module fetch_unit #(
  parameter int ADDR_WIDTH      = 32,
  parameter int QUEUE_DEPTH     = 4,
  parameter int MAX_OUTSTANDING = 2,
  parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = ADDR_WIDTH'(32'h1c00_0000)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic [ADDR_WIDTH-1:0] flush_pc,
  input  logic                  branch,
  input  logic [ADDR_WIDTH-1:0] predict_pc,
  input  logic                  stall,
  input  logic                  ns_ready,
  output logic                  req_valid,
  output logic [ADDR_WIDTH-1:0] req_addr,
  input  logic                  req_addr_ok,
  input  logic                  resp_data_ok,
  input  logic [ADDR_WIDTH-1:0] resp_rdata,
  output logic                  out_valid,
  output logic [ADDR_WIDTH-1:0] out_pc,
  output logic [ADDR_WIDTH-1:0] out_inst,
  output logic                  out_adef
);

  localparam int QW = $clog2(QUEUE_DEPTH);
  localparam int CW = QW + 1;
  localparam int TW = (MAX_OUTSTANDING > 1) ? $clog2(MAX_OUTSTANDING) : 1;
  localparam int IW = $clog2(MAX_OUTSTANDING + 1);

  typedef struct packed {
    logic [ADDR_WIDTH-1:0] pc;
    logic [ADDR_WIDTH-1:0] inst;
    logic                  adef;
  } entry_t;

  typedef enum logic {S_FETCH, S_HALT} state_t;

  state_t state, state_nxt;

  logic [ADDR_WIDTH-1:0] fpc;
  logic [IW-1:0]         inflight;
  logic [IW-1:0]         discard;
  logic [CW-1:0]         count;

  // fetch queue (power-of-two depth, pointers wrap naturally)
  entry_t                q_mem [QUEUE_DEPTH];
  logic [QW-1:0]         q_head, q_tail;

  // tag FIFO: PC of every accepted request, consumed by kept responses
  logic [ADDR_WIDTH-1:0] tag_mem [MAX_OUTSTANDING];
  logic [TW-1:0]         tag_rd, tag_wr;

  int     occ;
  logic   accept, resp_drop, resp_push, adef_push, push, pop;
  entry_t push_ent;

  // MAX_OUTSTANDING need not be a power of two, so wrap explicitly
  function automatic logic [TW-1:0] tag_next(input logic [TW-1:0] p);
    return (p == TW'(MAX_OUTSTANDING - 1)) ? '0 : p + TW'(1);
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk) begin
    if (rst) state <= S_FETCH;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    if (flush)          state_nxt = S_FETCH;
    else if (adef_push) state_nxt = S_HALT;
  end

  // occ counts queue slots already promised: queued entries plus responses
  // still expected that will be kept. Issuing only while occ < depth means
  // every kept response is guaranteed a slot.
  always_comb begin
    occ       = int'(count) + int'(inflight) - int'(discard);
    req_valid = 1'b0;
    adef_push = 1'b0;
    if (state == S_FETCH && !rst && !flush) begin
      req_valid = (fpc[1:0] == 2'b00) && (int'(inflight) < MAX_OUTSTANDING) &&
                  (occ < QUEUE_DEPTH);
      // the error entry must land behind every kept response, so wait until
      // only to-be-dropped responses remain in flight
      adef_push = (fpc[1:0] != 2'b00) && (inflight == discard) &&
                  (int'(count) < QUEUE_DEPTH);
    end
  end

  // ---------------------------------------------------------------- datapath
  assign req_addr  = fpc;
  assign accept    = req_valid && req_addr_ok;
  assign resp_drop = resp_data_ok && (discard != '0);
  assign resp_push = resp_data_ok && (discard == '0);
  assign push      = !rst && !flush && (resp_push || adef_push);
  assign pop       = out_valid && ns_ready && !stall;

  // adef_push only fires when every in-flight response is being dropped,
  // so it never competes with a kept response for the push port
  always_comb begin
    if (adef_push) push_ent = '{pc: fpc, inst: '0, adef: 1'b1};
    else           push_ent = '{pc: tag_mem[tag_rd], inst: resp_rdata, adef: 1'b0};
  end

  assign out_valid = (count != '0) && !flush;
  assign out_pc    = q_mem[q_head].pc;
  assign out_inst  = q_mem[q_head].inst;
  assign out_adef  = q_mem[q_head].adef;

  always_ff @(posedge clk) begin
    if (rst) begin
      fpc      <= RESET_VECTOR;
      inflight <= '0;
      discard  <= '0;
      count    <= '0;
      q_head   <= '0;
      q_tail   <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
    end else if (flush) begin
      // every request still in flight after this edge returns stale data
      fpc      <= flush_pc;
      inflight <= inflight - IW'(resp_data_ok);
      discard  <= inflight - IW'(resp_data_ok);
      count    <= '0;
      q_head   <= '0;
      q_tail   <= '0;
      tag_rd   <= '0;
      tag_wr   <= '0;
    end else begin
      if (accept) fpc <= branch ? predict_pc : fpc + ADDR_WIDTH'(4);
      inflight <= inflight + IW'(accept) - IW'(resp_data_ok);
      if (resp_drop) discard <= discard - IW'(1);
      if (accept)    tag_wr  <= tag_next(tag_wr);
      if (resp_push) tag_rd  <= tag_next(tag_rd);
      if (push)      q_tail  <= q_tail + QW'(1);
      if (pop)       q_head  <= q_head + QW'(1);
      count <= count + CW'(push) - CW'(pop);
    end
  end

  // storage arrays carry no reset; validity lives in the pointers/counters
  always_ff @(posedge clk) begin
    if (accept) tag_mem[tag_wr] <= fpc;
    if (push)   q_mem[q_tail]   <= push_ent;
  end

  // a kept response into a full queue means the reservation was broken
  a_no_push_when_full: assert property (@(posedge clk) disable iff (rst)
    !(resp_push && !flush && (count == CW'(QUEUE_DEPTH)) && !pop));

endmodule

// File: tb/tb_fetch_unit.sv
module tb_fetch_unit;
  localparam logic [31:0] RV = 32'h1c00_0000;

  logic        clk = 1'b0;
  logic        rst, flush, branch, stall, ns_ready, req_addr_ok;
  logic        resp_data_ok, req_valid, out_valid, out_adef;
  logic [31:0] flush_pc, predict_pc, resp_rdata, req_addr, out_pc, out_inst;

  always #5 clk = ~clk;

  fetch_unit dut (
    .clk(clk), .rst(rst), .flush(flush), .flush_pc(flush_pc),
    .branch(branch), .predict_pc(predict_pc), .stall(stall), .ns_ready(ns_ready),
    .req_valid(req_valid), .req_addr(req_addr), .req_addr_ok(req_addr_ok),
    .resp_data_ok(resp_data_ok), .resp_rdata(resp_rdata),
    .out_valid(out_valid), .out_pc(out_pc), .out_inst(out_inst), .out_adef(out_adef)
  );

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] inst;
    logic        adef;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] pend[$];
  logic [31:0] acc_log[$];
  exp_t        e;
  int          tests = 0, fails = 0, n_pop = 0;
  bit          resp_en = 1'b1;

  // icache: answers the oldest pending request one cycle after acceptance;
  // instruction word is the bitwise inverse of its address
  always @(negedge clk) begin
    #1;
    resp_data_ok = resp_en && !rst && (pend.size() > 0);
    resp_rdata   = (pend.size() > 0) ? ~pend[0] : 32'h0;
  end

  // pre-edge sampler: sees exactly what the DUT sees at the next rising edge
  always @(negedge clk) begin
    #4;
    if (rst) begin
      pend.delete();
    end else begin
      if (resp_data_ok) void'(pend.pop_front());
      if (req_valid && req_addr_ok) begin
        pend.push_back(req_addr);
        acc_log.push_back(req_addr);
      end
      if (out_valid && ns_ready && !stall) begin
        n_pop++;
        tests++;
        if (exp_q.size() == 0) begin
          fails++;
          $display("FAIL out_unexpected: got pc=%h inst=%h adef=%b, required no output",
                   out_pc, out_inst, out_adef);
        end else begin
          e = exp_q.pop_front();
          if ({out_pc, out_inst, out_adef} !== {e.pc, e.inst, e.adef}) begin
            fails++;
            $display("FAIL out_entry: got pc=%h inst=%h adef=%b, required pc=%h inst=%h adef=%b",
                     out_pc, out_inst, out_adef, e.pc, e.inst, e.adef);
          end
        end
      end
    end
  end

  task automatic tick();
    @(negedge clk);
  endtask

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    tests++;
    if (got !== want) begin
      fails++;
      $display("FAIL %s: got %h, required %h", nm, got, want);
    end
  endtask

  task automatic ex(input logic [31:0] pc, input logic adef);
    exp_t t;
    t.pc   = pc;
    t.inst = adef ? 32'h0 : ~pc;
    t.adef = adef;
    exp_q.push_back(t);
  endtask

  task automatic wait_acc(input int target);
    int k = 0;
    while (acc_log.size() < target && k < 50) begin
      tick();
      k++;
    end
    if (acc_log.size() < target) begin
      tests++;
      fails++;
      $display("FAIL accept_timeout: got %0d accepts, required %0d", acc_log.size(), target);
    end
  endtask

  task automatic issue(input int n, input logic br, input logic [31:0] tgt);
    int base = acc_log.size();
    branch      = br;
    predict_pc  = tgt;
    req_addr_ok = 1'b1;
    wait_acc(base + 1);
    branch = 1'b0;
    wait_acc(base + n);
    req_addr_ok = 1'b0;
  endtask

  task automatic wait_drain();
    int k = 0;
    while (exp_q.size() != 0 && k < 60) begin
      tick();
      k++;
    end
    if (exp_q.size() != 0) begin
      tests++;
      fails++;
      $display("FAIL drain_timeout: got %0d entries outstanding, required 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic flush_op(input logic [31:0] pc);
    flush    = 1'b1;
    flush_pc = pc;
    tick();
    flush = 1'b0;
  endtask

  initial begin
    int base, p;
    rst = 1'b1; flush = 1'b0; flush_pc = '0; branch = 1'b0; predict_pc = '0;
    stall = 1'b0; ns_ready = 1'b1; req_addr_ok = 1'b0;
    repeat (3) tick();
    chk("rst_req_valid", 32'(req_valid), 32'h0);
    chk("rst_out_valid", 32'(out_valid), 32'h0);
    chk("rst_req_addr", req_addr, RV);
    rst = 1'b0;

    // sequential fetch with single-cycle icache latency
    ex(RV, 0); ex(RV + 4, 0); ex(RV + 8, 0);
    issue(3, 1'b0, '0);
    wait_drain();
    chk("seq_addr0", acc_log[0], RV);
    chk("seq_addr1", acc_log[1], RV + 4);
    chk("seq_addr2", acc_log[2], RV + 8);

    // backpressure: queue fills to 4, requests stop, nothing lost
    ns_ready = 1'b0;
    base = acc_log.size();
    ex(RV + 'h0c, 0); ex(RV + 'h10, 0); ex(RV + 'h14, 0); ex(RV + 'h18, 0);
    req_addr_ok = 1'b1;
    repeat (10) tick();
    chk("fill_accepts", 32'(acc_log.size() - base), 32'd4);
    chk("fill_req_valid", 32'(req_valid), 32'h0);
    chk("fill_out_valid", 32'(out_valid), 32'h1);
    req_addr_ok = 1'b0;
    ns_ready = 1'b1;
    stall = 1'b1;
    p = n_pop;
    repeat (3) tick();
    chk("stall_no_pop", 32'(n_pop - p), 32'h0);
    stall = 1'b0;
    wait_drain();

    // predicted-taken branch on the accept of RV+4
    flush_op(RV + 4);
    base = acc_log.size();
    ex(RV + 4, 0); ex(RV + 'h40, 0); ex(RV + 'h44, 0);
    issue(3, 1'b1, RV + 'h40);
    wait_drain();
    chk("branch_target", acc_log[base + 1], RV + 'h40);

    // two in flight, flush: both late responses dropped
    resp_en = 1'b0;
    issue(2, 1'b0, '0);
    flush_op(RV + 'h100);
    resp_en = 1'b1;
    base = acc_log.size();
    ex(RV + 'h100, 0);
    issue(1, 1'b0, '0);
    wait_drain();
    chk("flush_redirect", acc_log[base], RV + 'h100);

    // flush coincides with a response while two are in flight: drop one more
    resp_en = 1'b0;
    issue(2, 1'b0, '0);
    flush = 1'b1; flush_pc = RV + 'h200; resp_en = 1'b1;
    tick();
    flush = 1'b0;
    ex(RV + 'h200, 0);
    issue(1, 1'b0, '0);
    wait_drain();

    // misaligned redirect: one address-error entry, no requests, HALT
    req_addr_ok = 1'b1;
    base = acc_log.size();
    ex(RV + 'h102, 1);
    flush_op(RV + 'h102);
    repeat (6) tick();
    chk("adef_no_accept", 32'(acc_log.size() - base), 32'h0);
    chk("adef_req_valid", 32'(req_valid), 32'h0);
    wait_drain();
    repeat (3) tick();
    chk("halt_out_valid", 32'(out_valid), 32'h0);
    chk("halt_req_valid", 32'(req_valid), 32'h0);
    req_addr_ok = 1'b0;
    ex(RV + 'h300, 0);
    flush_op(RV + 'h300);
    issue(1, 1'b0, '0);
    wait_drain();

    // reset mid-operation abandons in-flight work
    resp_en = 1'b0;
    issue(2, 1'b0, '0);
    rst = 1'b1;
    repeat (2) tick();
    chk("midrst_req_valid", 32'(req_valid), 32'h0);
    rst = 1'b0;
    resp_en = 1'b1;
    chk("midrst_req_addr", req_addr, RV);
    chk("midrst_out_valid", 32'(out_valid), 32'h0);
    ex(RV, 0);
    issue(1, 1'b0, '0);
    wait_drain();
    repeat (4) tick();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/fetch_unit.md
FETCH_UNIT -- requirements
Module: fetch_unit

Interface
REQ-001 Parameter ADDR_WIDTH, default 32, address and instruction width.
REQ-002 Parameter QUEUE_DEPTH, default 4, fetch-queue entries; power of two, at least 2.
REQ-003 Parameter MAX_OUTSTANDING, default 2, icache requests in flight; at least 1, at most QUEUE_DEPTH.
REQ-004 Parameter RESET_VECTOR, default 32'h1c000000, PC after reset.
REQ-005 Port clk, input, 1, single clock; all state updates on the rising edge.
REQ-006 Port rst, input, 1, reset; synchronous, active-high.
REQ-007 Port flush, input, 1, redirect and discard all fetch state.
REQ-008 Port flush_pc, input, ADDR_WIDTH, redirect target.
REQ-009 Port branch, input, 1, predictor taken for the current fetch PC.
REQ-010 Port predict_pc, input, ADDR_WIDTH, predicted target for the current fetch PC.
REQ-011 Port stall, input, 1, downstream hold.
REQ-012 Port ns_ready, input, 1, next stage can accept.
REQ-013 Port req_valid, output, 1, icache request valid.
REQ-014 Port req_addr, output, ADDR_WIDTH, icache request address.
REQ-015 Port req_addr_ok, input, 1, icache accepted request.
REQ-016 Port resp_data_ok, input, 1, icache returns one instruction, in request order.
REQ-017 Port resp_rdata, input, ADDR_WIDTH, returned instruction.
REQ-018 Port out_valid, output, 1, head of queue presented.
REQ-019 Port out_pc, output, ADDR_WIDTH, PC of the head entry.
REQ-020 Port out_inst, output, ADDR_WIDTH, instruction of the head entry; 0 when out_adef is set.
REQ-021 Port out_adef, output, 1, head entry carries an address-error fetch exception.

Function
REQ-022 Internal counters: fpc (fetch PC), inflight (accepted requests not yet answered, 0..MAX_OUTSTANDING), discard (responses still to drop), count (queue occupancy); state is FETCH or HALT.
REQ-023 Tag FIFO: depth MAX_OUTSTANDING; stores fpc on each accepted request; popped on each non-discarded response.
REQ-024 req_valid is asserted when all hold: state FETCH, !rst, !flush, fpc[1:0]==0, inflight<MAX_OUTSTANDING, and count+inflight-discard<QUEUE_DEPTH.
REQ-025 req_addr always equals fpc.
REQ-026 An accept is req_valid && req_addr_ok; on accept, fpc becomes predict_pc if branch is set, otherwise fpc+4 with wrap modulo 2^ADDR_WIDTH.
REQ-027 fpc is held in any cycle without an accept or flush.
REQ-028 On resp_data_ok with discard>0, discard decrements, inflight decrements, and the data is dropped.
REQ-029 On resp_data_ok with discard==0, the tag head is popped and {tag, resp_rdata, adef=0} is pushed to the queue.
REQ-030 Misaligned fetch: in state FETCH, if fpc[1:0]!=0, inflight==discard and count<QUEUE_DEPTH, push {fpc, 0, adef=1} and go to HALT.
REQ-031 HALT issues no requests and leaves only on flush.
REQ-032 A pop occurs on out_valid && ns_ready && !stall; the queue supports a push and a pop in the same cycle.
REQ-033 out_valid = count>0 && !flush; out_pc, out_inst and out_adef come from the head entry.
REQ-034 Flush has priority over every other event: fpc<=flush_pc, count<=0, tag FIFO cleared, state<=FETCH, discard<=inflight-resp_data_ok, inflight<=inflight-resp_data_ok; no push or pop that cycle.
REQ-035 Reservation (REQ-024) guarantees no push when the queue is full; a response arriving when full is a design error and is flagged by assertion.
REQ-036 Same-cycle accept and response: inflight stays unchanged.

Reset
REQ-037 On rst: fpc=RESET_VECTOR, count=0, inflight=0, discard=0, tag FIFO empty, state FETCH; req_valid=0 and out_valid=0 during rst.
REQ-038 Reset mid-operation abandons in-flight responses; the icache is reset by the same rst.

Verification
REQ-039 Reset, then req_addr_ok=1 and single-cycle data_ok latency -> requests at 1c000000, 1c000004, 1c000008; outputs appear in order with matching out_pc.
REQ-040 ns_ready=0 with default parameters -> at most 4 entries held; req_valid drops once count+inflight=4; no entry is lost when ns_ready returns to 1.
REQ-041 Two requests in flight, then flush with flush_pc=1c000100 -> both late responses are dropped; first output is from 1c000100.
REQ-042 branch=1, predict_pc=1c000040 on accept of 1c000004 -> next req_addr is 1c000040.
REQ-043 flush_pc=1c000102 -> no request issued; one entry with out_adef=1, out_pc=1c000102, out_inst=0; state HALT until the next flush.
REQ-044 Flush in the same cycle as resp_data_ok, with inflight=2 -> discard=1; exactly one following response is dropped.
